// File: rtl/batch_stream_arbiter.sv
// Round-robin, batch-granular arbiter: shares one downstream stream between
// NUM_SRC batch collectors. A granted source keeps the stream until its batch
// ends (tlast, size limit) or it goes quiet for STALL_TIMEOUT cycles.
module batch_stream_arbiter #(
    parameter int NUM_SRC          = 4,
    parameter int MAX_DEPENDENCIES = 256,
    parameter int MAX_BATCH_SIZE   = 8,
    parameter int STALL_TIMEOUT    = 64,
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int IW = $clog2(STALL_TIMEOUT + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_SRC-1:0]                    s_axis_tvalid,
    output logic [NUM_SRC-1:0]                    s_axis_tready,
    input  logic [NUM_SRC-1:0]                    s_axis_tlast,
    input  logic [64*NUM_SRC-1:0]                 s_axis_tdata_owner_programID,
    input  logic [MAX_DEPENDENCIES*NUM_SRC-1:0]   s_axis_tdata_read_dependencies,
    input  logic [MAX_DEPENDENCIES*NUM_SRC-1:0]   s_axis_tdata_write_dependencies,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic [SW-1:0]                         m_axis_tsrc,
    output logic [63:0]                           m_axis_tdata_owner_programID,
    output logic [MAX_DEPENDENCIES-1:0]           m_axis_tdata_read_dependencies,
    output logic [MAX_DEPENDENCIES-1:0]           m_axis_tdata_write_dependencies,
    output logic                                  batch_completed,
    output logic                                  batch_aborted,
    output logic [31:0]                           batches_dispatched,
    output logic [31:0]                           stall_aborts
);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   grant_idx_q, grant_idx_d;
    logic [SW-1:0]   rr_last_q, rr_last_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [31:0]     batches_q, batches_d;
    logic [31:0]     aborts_q, aborts_d;
    logic            completed_q, completed_d;
    logic            aborted_q, aborted_d;

    logic [63:0]                 owner_arr [NUM_SRC];
    logic [MAX_DEPENDENCIES-1:0] rd_arr    [NUM_SRC];
    logic [MAX_DEPENDENCIES-1:0] wr_arr    [NUM_SRC];

    logic            streaming;
    logic            g_valid;
    logic            size_hit;
    logic            beat;
    logic            rr_found;
    logic [SW-1:0]   rr_pick;
    logic [SW-1:0]   rr_cand;

    assign streaming = (state_q == ST_STREAM);
    assign g_valid   = s_axis_tvalid[grant_idx_q];
    assign size_hit  = (beat_cnt_q == 8'(MAX_BATCH_SIZE - 1));

    // Per-source unpacking and ready steering: only the granted lane sees downstream ready
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign owner_arr[gi]     = s_axis_tdata_owner_programID[64*gi +: 64];
        assign rd_arr[gi]        = s_axis_tdata_read_dependencies[MAX_DEPENDENCIES*gi +: MAX_DEPENDENCIES];
        assign wr_arr[gi]        = s_axis_tdata_write_dependencies[MAX_DEPENDENCIES*gi +: MAX_DEPENDENCIES];
        assign s_axis_tready[gi] = streaming & (grant_idx_q == SW'(gi)) & m_axis_tready;
    end

    // Zero-latency passthrough of the granted source; tlast also forced at the size limit
    assign m_axis_tvalid                   = streaming & g_valid;
    assign m_axis_tlast                    = streaming & (s_axis_tlast[grant_idx_q] | size_hit);
    assign m_axis_tsrc                     = grant_idx_q;
    assign m_axis_tdata_owner_programID    = owner_arr[grant_idx_q];
    assign m_axis_tdata_read_dependencies  = rd_arr[grant_idx_q];
    assign m_axis_tdata_write_dependencies = wr_arr[grant_idx_q];
    assign beat                            = m_axis_tvalid & m_axis_tready;

    assign batch_completed    = completed_q;
    assign batch_aborted      = aborted_q;
    assign batches_dispatched = batches_q;
    assign stall_aborts       = aborts_q;

    // Round-robin search: first valid source starting just after the last owner
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            rr_cand = SW'((int'(rr_last_q) + k) % NUM_SRC);
            if (!rr_found && s_axis_tvalid[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    // Next-state: grant in IDLE, track beats and idle time in STREAM, end or abort the batch
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_last_d   = rr_last_q;
        beat_cnt_d  = beat_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        batches_d   = batches_q;
        aborts_d    = aborts_q;
        completed_d = 1'b0;
        aborted_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    state_d     = ST_STREAM;
                    grant_idx_d = rr_pick;
                    beat_cnt_d  = '0;
                    idle_cnt_d  = '0;
                end
            end
            ST_STREAM: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    idle_cnt_d = '0;
                    if (m_axis_tlast) begin
                        completed_d = 1'b1;
                        batches_d   = batches_q + 32'd1;
                        rr_last_d   = grant_idx_q;
                        state_d     = ST_IDLE;
                    end
                end else if (!g_valid) begin
                    // Backpressure with valid held is not idle; only a silent source counts
                    if (idle_cnt_q == IW'(STALL_TIMEOUT - 1)) begin
                        aborted_d = 1'b1;
                        aborts_d  = aborts_q + 32'd1;
                        rr_last_d = grant_idx_q;
                        state_d   = ST_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            rr_last_q   <= SW'(NUM_SRC - 1);
            beat_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            batches_q   <= '0;
            aborts_q    <= '0;
            completed_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_last_q   <= rr_last_d;
            beat_cnt_q  <= beat_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            batches_q   <= batches_d;
            aborts_q    <= aborts_d;
            completed_q <= completed_d;
            aborted_q   <= aborted_d;
        end
    end

endmodule

// File: tb/tb_batch_stream_arbiter.sv
// Directed bench for batch_stream_arbiter: batch passthrough, round-robin order,
// size-limit end, stall abort, backpressure and mid-batch reset.
module tb_batch_stream_arbiter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    s_tvalid, s_tready, s_tlast;
    logic [255:0]  s_owner;
    logic [1023:0] s_rd, s_wr;
    logic          m_tvalid, m_tready, m_tlast;
    logic [1:0]    m_tsrc;
    logic [63:0]   m_owner;
    logic [255:0]  m_rd, m_wr;
    logic          completed, aborted;
    logic [31:0]   batches, aborts;

    int vectors = 0;
    int miscompares = 0;
    int beatn [4];

    always #5 clk = ~clk;

    batch_stream_arbiter dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .s_axis_tvalid                   (s_tvalid),
        .s_axis_tready                   (s_tready),
        .s_axis_tlast                    (s_tlast),
        .s_axis_tdata_owner_programID    (s_owner),
        .s_axis_tdata_read_dependencies  (s_rd),
        .s_axis_tdata_write_dependencies (s_wr),
        .m_axis_tvalid                   (m_tvalid),
        .m_axis_tready                   (m_tready),
        .m_axis_tlast                    (m_tlast),
        .m_axis_tsrc                     (m_tsrc),
        .m_axis_tdata_owner_programID    (m_owner),
        .m_axis_tdata_read_dependencies  (m_rd),
        .m_axis_tdata_write_dependencies (m_wr),
        .batch_completed                 (completed),
        .batch_aborted                   (aborted),
        .batches_dispatched              (batches),
        .stall_aborts                    (aborts)
    );

    function automatic logic [63:0] own_val(input int s, input int b);
        return 64'hC0DE_0000_0000_0000 | (64'(s) << 32) | 64'(b);
    endfunction

    function automatic logic [255:0] rd_val(input int s, input int b);
        return (256'(own_val(s, b)) << 100) | 256'(b + 1);
    endfunction

    function automatic logic [3:0] onehot(input int s);
        logic [3:0] one;
        one = 4'b0001;
        return one << s;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_src(input int s, input logic v, input logic l);
        s_tvalid[s]         = v;
        s_tlast[s]          = l;
        s_owner[64*s +: 64] = own_val(s, beatn[s]);
        s_rd[256*s +: 256]  = rd_val(s, beatn[s]);
        s_wr[256*s +: 256]  = ~rd_val(s, beatn[s]);
    endtask

    // One accepted beat from source s
    task automatic beat_cycle(input int s, input logic last_in, input logic exp_last);
        drive_src(s, 1'b1, last_in);
        @(negedge clk);
        $display("beat src=%0d n=%0d tlast=%0b", s, beatn[s], m_tlast);
        chk("beat_valid", 256'(m_tvalid), 256'(1));
        chk("beat_tsrc",  256'(m_tsrc),   256'(s));
        chk("beat_tlast", 256'(m_tlast),  256'(exp_last));
        chk("beat_tready", 256'(s_tready), 256'(onehot(s)));
        chk("beat_owner", 256'(m_owner),  256'(own_val(s, beatn[s])));
        chk("beat_rd",    m_rd,           rd_val(s, beatn[s]));
        chk("beat_wr",    m_wr,           ~rd_val(s, beatn[s]));
        tick();
        beatn[s]++;
    endtask

    // One IDLE (arbitration) cycle
    task automatic idle_cycle(input logic exp_c, input logic exp_a);
        @(negedge clk);
        $display("idle completed=%0b aborted=%0b", completed, aborted);
        chk("idle_valid",  256'(m_tvalid),  256'(0));
        chk("idle_tready", 256'(s_tready),  256'(0));
        chk("idle_tlast",  256'(m_tlast),   256'(0));
        chk("idle_compl",  256'(completed), 256'(exp_c));
        chk("idle_abort",  256'(aborted),   256'(exp_a));
        tick();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tready", 256'(s_tready),  256'(0));
        chk("rst_valid",  256'(m_tvalid),  256'(0));
        chk("rst_tlast",  256'(m_tlast),   256'(0));
        chk("rst_tsrc",   256'(m_tsrc),    256'(0));
        chk("rst_compl",  256'(completed), 256'(0));
        chk("rst_abort",  256'(aborted),   256'(0));
        chk("rst_batches", 256'(batches),  256'(0));
        chk("rst_aborts", 256'(aborts),    256'(0));
    endtask

    initial begin
        rst_n    = 1'b0;
        m_tready = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_owner  = '0;
        s_rd     = '0;
        s_wr     = '0;
        for (int i = 0; i < 4; i++) beatn[i] = 0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        $display("reset state check");
        chk_reset_outputs();
        rst_n = 1'b1;
        tick();

        // 1: src0, three beats with tlast on the third
        drive_src(0, 1'b1, 1'b0);
        idle_cycle(1'b0, 1'b0);
        beat_cycle(0, 1'b0, 1'b0);
        beat_cycle(0, 1'b0, 1'b0);
        beat_cycle(0, 1'b1, 1'b1);
        drive_src(0, 1'b0, 1'b0);
        idle_cycle(1'b1, 1'b0);
        chk("t1_batches", 256'(batches), 256'(1));
        idle_cycle(1'b0, 1'b0);

        // 2: all sources busy, 2-beat batches, order 0,1,2,3,0 after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beatn[i] = 0;
            drive_src(i, 1'b1, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            idle_cycle(k > 0, 1'b0);
            beat_cycle(k % 4, 1'b0, 1'b0);
            beat_cycle(k % 4, 1'b1, 1'b1);
        end
        s_tvalid = '0;
        idle_cycle(1'b1, 1'b0);
        chk("t2_batches", 256'(batches), 256'(5));

        // 3: src2 never sets tlast; size limit ends the batch at beat 8
        drive_src(2, 1'b1, 1'b0);
        idle_cycle(1'b0, 1'b0);
        for (int b = 0; b < 8; b++) beat_cycle(2, 1'b0, b == 7);
        drive_src(2, 1'b1, 1'b0);
        idle_cycle(1'b1, 1'b0);
        chk("t3_batches", 256'(batches), 256'(6));
        beat_cycle(2, 1'b1, 1'b1);
        s_tvalid = '0;
        idle_cycle(1'b1, 1'b0);
        chk("t3_batches2", 256'(batches), 256'(7));

        // 4: src1 goes silent after one beat; abort after 64 idle cycles, then src2
        drive_src(1, 1'b1, 1'b0);
        drive_src(2, 1'b1, 1'b0);
        idle_cycle(1'b0, 1'b0);
        beat_cycle(1, 1'b0, 1'b0);
        s_tvalid[1] = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            chk("t4_valid",  256'(m_tvalid), 256'(0));
            chk("t4_tsrc",   256'(m_tsrc),   256'(1));
            chk("t4_abort",  256'(aborted),  256'(0));
            tick();
        end
        idle_cycle(1'b0, 1'b1);
        chk("t4_aborts",  256'(aborts),  256'(1));
        chk("t4_batches", 256'(batches), 256'(7));
        beat_cycle(2, 1'b1, 1'b1);
        s_tvalid = '0;
        idle_cycle(1'b1, 1'b0);

        // 5: 200 cycles of downstream backpressure is not a stall
        drive_src(0, 1'b1, 1'b0);
        idle_cycle(1'b0, 1'b0);
        m_tready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            chk("t5_valid",  256'(m_tvalid), 256'(1));
            chk("t5_tready", 256'(s_tready), 256'(0));
            chk("t5_owner",  256'(m_owner),  256'(own_val(0, beatn[0])));
            chk("t5_abort",  256'(aborted),  256'(0));
            tick();
        end
        m_tready = 1'b1;
        beat_cycle(0, 1'b1, 1'b1);
        s_tvalid = '0;
        idle_cycle(1'b1, 1'b0);
        chk("t5_batches", 256'(batches), 256'(9));
        chk("t5_aborts",  256'(aborts),  256'(1));

        // 6: reset in the middle of a src3 batch
        drive_src(3, 1'b1, 1'b0);
        idle_cycle(1'b0, 1'b0);
        beat_cycle(3, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        $display("mid-batch reset check");
        chk_reset_outputs();
        rst_n = 1'b1;
        drive_src(0, 1'b1, 1'b0);
        drive_src(3, 1'b1, 1'b0);
        tick();
        beat_cycle(0, 1'b1, 1'b1);
        s_tvalid = '0;
        idle_cycle(1'b1, 1'b0);
        chk("t6_batches", 256'(batches), 256'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
